// File: rtl/dac_ramp_sequencer_if.sv
// Control/status bundle between the pin-level control logic and the DAC ramp
// sequencer.
//   master : issues start/stop and the ramp configuration, observes status
//   slave  : the sequencer itself
// Signals:
//   start, stop              one-cycle requests
//   mode[1:0]                0=oneshot up, 1=sawtooth, 2=triangle, 3=oneshot down
//   lo, hi, step, dwell      ramp limits, increment, extra hold cycles
//   on_word[127:0]           thermometer ON word to the DAC macro
//   dac_en                   DAC enable
//   code[7:0]                current code
//   busy, wrap, done, err    status and one-cycle event pulses
interface dac_ramp_sequencer_if;
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic [7:0]   lo;
  logic [7:0]   hi;
  logic [7:0]   step;
  logic [7:0]   dwell;
  logic [127:0] on_word;
  logic         dac_en;
  logic [7:0]   code;
  logic         busy;
  logic         wrap;
  logic         done;
  logic         err;

  modport master (
    output start, stop, mode, lo, hi, step, dwell,
    input  on_word, dac_en, code, busy, wrap, done, err
  );

  modport slave (
    input  start, stop, mode, lo, hi, step, dwell,
    output on_word, dac_en, code, busy, wrap, done, err
  );
endinterface

// File: rtl/dac_ramp_sequencer.sv
// DAC ramp sequencer: drives the 128-source unary current-steering DAC with a
// thermometer ON word generated from an 8-bit code that ramps between the
// latched limits, and frames each sequence with SETTLE_CYC cycles of
// enable-with-zero-word before (ARM) and after (DRAIN) the ramp.
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    dac_ramp_sequencer_if.slave (requests, config, ON word, status)
module dac_ramp_sequencer #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  dac_ramp_sequencer_if.slave  bus
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    code_q, code_d;
  logic [127:0]  on_word_q, on_word_d;
  logic          dac_en_q, dac_en_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    hold_q, hold_d;
  logic          dir_dn_q, dir_dn_d;
  logic          cmpl_q, cmpl_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    dwell_q, dwell_d;

  logic [7:0]    step_eff;
  logic [8:0]    up_sum;
  logic [8:0]    dn_diff;
  logic [7:0]    up_nxt;
  logic [7:0]    dn_nxt;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    dir_dn_d = dir_dn_q;
    cmpl_d   = cmpl_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Next-code candidates, 9 bits wide so overflow/underflow clamp cleanly.
    step_eff = (step_q == 8'd0) ? 8'd1 : step_q;
    up_sum   = {1'b0, code_q} + {1'b0, step_eff};
    dn_diff  = {1'b0, code_q} - {1'b0, step_eff};
    up_nxt   = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[7:0];
    dn_nxt   = (dn_diff[8] || (dn_diff[7:0] <= lo_q)) ? lo_q : dn_diff[7:0];

    unique case (state_q)
      S_IDLE: begin
        code_d = '0;
        if (bus.start) begin
          if ((bus.lo <= bus.hi) && (bus.hi <= 8'd128)) begin
            mode_d   = bus.mode;
            lo_d     = bus.lo;
            hi_d     = bus.hi;
            step_d   = bus.step;
            dwell_d  = bus.dwell;
            dir_dn_d = 1'b0;
            cmpl_d   = 1'b0;
            cnt_d    = SETTLE_LOAD;
            state_d  = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ARM: begin
        if (bus.stop) begin
          cmpl_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
          code_d  = '0;
          state_d = S_DRAIN;
        end else if (cnt_q == '0) begin
          code_d  = (mode_q == 2'd3) ? hi_q : lo_q;
          hold_d  = dwell_q;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_RUN: begin
        if (bus.stop) begin
          cmpl_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
          code_d  = '0;
          state_d = S_DRAIN;
        end else if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          hold_d = dwell_q;
          unique case (mode_q)
            2'd0: begin
              if (code_q == hi_q) begin
                cmpl_d  = 1'b1;
                cnt_d   = SETTLE_LOAD;
                code_d  = '0;
                state_d = S_DRAIN;
              end else begin
                code_d = up_nxt;
              end
            end
            2'd1: begin
              if (code_q == hi_q) begin
                code_d = lo_q;
                wrap_d = 1'b1;
              end else begin
                code_d = up_nxt;
              end
            end
            2'd2: begin
              // A degenerate triangle never moves; every hold ends a period.
              if (lo_q == hi_q) begin
                wrap_d = 1'b1;
              end else if (!dir_dn_q) begin
                code_d = up_nxt;
                if (up_nxt == hi_q) dir_dn_d = 1'b1;
              end else begin
                code_d = dn_nxt;
                if (dn_nxt == lo_q) begin
                  dir_dn_d = 1'b0;
                  wrap_d   = 1'b1;
                end
              end
            end
            default: begin
              if (code_q == lo_q) begin
                cmpl_d  = 1'b1;
                cnt_d   = SETTLE_LOAD;
                code_d  = '0;
                state_d = S_DRAIN;
              end else begin
                code_d = dn_nxt;
              end
            end
          endcase
        end
      end

      default: begin
        code_d = '0;
        if (cnt_q == '0) begin
          done_d  = cmpl_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase

    // Shift of an all-ones word by 128 yields zero, so code=128 decodes to all ones.
    on_word_d = ~({128{1'b1}} << code_d);
    busy_d    = (state_d != S_IDLE);
    dac_en_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      on_word_q <= '0;
      dac_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      dir_dn_q  <= 1'b0;
      cmpl_q    <= 1'b0;
      mode_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      on_word_q <= on_word_d;
      dac_en_q  <= dac_en_d;
      busy_q    <= busy_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      dir_dn_q  <= dir_dn_d;
      cmpl_q    <= cmpl_d;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.on_word = on_word_q;
  assign bus.dac_en  = dac_en_q;
  assign bus.code    = code_q;
  assign bus.busy    = busy_q;
  assign bus.wrap    = wrap_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Scoreboard bench for dac_ramp_sequencer. The driver pushes hand-computed
// expected output events (with the cycle gap since the previous event, 0 =
// don't care) before issuing each sequence; the monitor detects an event
// whenever code/on_word/dac_en/busy change or any pulse is high, and pops and
// compares. A stretched pulse shows up as an extra, unexpected event.
module tb_dac_ramp_sequencer;

  logic clk;
  logic rst_n;

  dac_ramp_sequencer_if bus ();

  dac_ramp_sequencer #(.SETTLE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned gap;
    bit [7:0]    code;
    bit          en;
    bit          busy;
    bit          wrap;
    bit          done;
    bit          err;
    int unsigned tnum;
    int unsigned idx;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned cur_test = 0;
  int unsigned ev_idx = 0;
  bit          mon_en = 1'b0;

  task automatic push(input int unsigned gap, input bit [7:0] code,
                      input bit en, input bit busy, input bit wrap,
                      input bit done, input bit err);
    ev_t e;
    e.gap = gap; e.code = code; e.en = en; e.busy = busy;
    e.wrap = wrap; e.done = done; e.err = err;
    e.tnum = cur_test; e.idx = ev_idx;
    ev_idx++;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin : monitor
    logic [137:0] prev_key, key;
    int unsigned  cyc, last;
    ev_t          e;
    logic [127:0] exp_ow;
    wait (mon_en);
    @(negedge clk);
    cyc = 0; last = 0;
    prev_key = {bus.code, bus.on_word, bus.dac_en, bus.busy};
    forever begin
      @(negedge clk);
      cyc++;
      key = {bus.code, bus.on_word, bus.dac_en, bus.busy};
      if ((key !== prev_key) || bus.wrap || bus.done || bus.err) begin
        int unsigned gap;
        gap = cyc - last;
        last = cyc;
        prev_key = key;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got code=%0d en=%b busy=%b wrap=%b done=%b err=%b, required no event",
                   bus.code, bus.dac_en, bus.busy, bus.wrap, bus.done, bus.err);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 128; i++) exp_ow[i] = (i < int'(e.code));
          if ((e.gap != 0 && gap != e.gap) || bus.code !== e.code ||
              bus.on_word !== exp_ow || bus.dac_en !== e.en ||
              bus.busy !== e.busy || bus.wrap !== e.wrap ||
              bus.done !== e.done || bus.err !== e.err) begin
            fails++;
            $display("FAIL ev_t%0d_%0d: got gap=%0d code=%0d on_word=%h en=%b busy=%b wrap=%b done=%b err=%b, required gap=%0d code=%0d on_word=%h en=%b busy=%b wrap=%b done=%b err=%b",
                     e.tnum, e.idx, gap, bus.code, bus.on_word, bus.dac_en, bus.busy,
                     bus.wrap, bus.done, bus.err, e.gap, e.code, exp_ow, e.en,
                     e.busy, e.wrap, e.done, e.err);
          end
        end
      end
    end
  end

  // Drives a start with the given config; returns #1 after the sampling edge
  // with the config scrambled so later latching would be visible.
  task automatic do_start(input bit [1:0] m, input bit [7:0] l, input bit [7:0] h,
                          input bit [7:0] s, input bit [7:0] d);
    @(posedge clk); #1;
    bus.mode = m; bus.lo = l; bus.hi = h; bus.step = s; bus.dwell = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode = ~m; bus.lo = 8'd200; bus.hi = 8'd3; bus.step = 8'd77; bus.dwell = 8'd9;
  endtask

  task automatic pulse_after(input int unsigned k, input bit do_start_p, input bit do_stop_p);
    repeat (k) @(posedge clk);
    #1;
    bus.start = do_start_p; bus.stop = do_stop_p;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy !== 1'b0) begin
      checks++; fails++;
      $display("FAIL idle_timeout_t%0d: busy=%b after %0d cycles, required 0", cur_test, bus.busy, n);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : driver
    int unsigned n;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = '0;
    bus.lo = '0; bus.hi = '0; bus.step = '0; bus.dwell = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.code !== 8'd0 || bus.on_word !== '0 || bus.dac_en !== 1'b0 ||
        bus.busy !== 1'b0 || bus.wrap !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got code=%0d on_word=%h en=%b busy=%b wrap=%b done=%b err=%b, required all 0",
               bus.code, bus.on_word, bus.dac_en, bus.busy, bus.wrap, bus.done, bus.err);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    // Test 1: oneshot up 0..10 step 3 dwell 1, plus a stop in IDLE (ignored)
    cur_test = 1; ev_idx = 0;
    pulse_after(0, 1'b0, 1'b1);
    push(0, 8'd0,  1, 1, 0, 0, 0);
    push(6, 8'd3,  1, 1, 0, 0, 0);
    push(2, 8'd6,  1, 1, 0, 0, 0);
    push(2, 8'd9,  1, 1, 0, 0, 0);
    push(2, 8'd10, 1, 1, 0, 0, 0);
    push(2, 8'd0,  1, 1, 0, 0, 0);
    push(4, 8'd0,  0, 0, 0, 1, 0);
    do_start(2'd0, 8'd0, 8'd10, 8'd3, 8'd1);
    wait_idle();

    // Test 2: sawtooth 120..128 step 4, stop after second wrap
    cur_test = 2; ev_idx = 0;
    push(0, 8'd0,   1, 1, 0, 0, 0);
    push(4, 8'd120, 1, 1, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      push(1, 8'd124, 1, 1, 0, 0, 0);
      push(1, 8'd128, 1, 1, 0, 0, 0);
      push(1, 8'd120, 1, 1, 1, 0, 0);
    end
    push(1, 8'd0, 1, 1, 0, 0, 0);
    push(4, 8'd0, 0, 0, 0, 0, 0);
    do_start(2'd1, 8'd120, 8'd128, 8'd4, 8'd0);
    pulse_after(10, 1'b0, 1'b1);
    wait_idle();

    // Test 3: triangle 2..5 step 2, stop mid-ramp
    cur_test = 3; ev_idx = 0;
    push(0, 8'd0, 1, 1, 0, 0, 0);
    push(4, 8'd2, 1, 1, 0, 0, 0);
    push(1, 8'd4, 1, 1, 0, 0, 0);
    push(1, 8'd5, 1, 1, 0, 0, 0);
    push(1, 8'd3, 1, 1, 0, 0, 0);
    push(1, 8'd2, 1, 1, 1, 0, 0);
    push(1, 8'd4, 1, 1, 0, 0, 0);
    push(1, 8'd5, 1, 1, 0, 0, 0);
    push(1, 8'd3, 1, 1, 0, 0, 0);
    push(1, 8'd0, 1, 1, 0, 0, 0);
    push(4, 8'd0, 0, 0, 0, 0, 0);
    do_start(2'd2, 8'd2, 8'd5, 8'd2, 8'd0);
    pulse_after(11, 1'b0, 1'b1);
    wait_idle();

    // Test 4: rejected starts
    cur_test = 4; ev_idx = 0;
    push(0, 8'd0, 0, 0, 0, 0, 1);
    push(0, 8'd0, 0, 0, 0, 0, 1);
    do_start(2'd0, 8'd9, 8'd4, 8'd1, 8'd0);
    repeat (4) @(posedge clk);
    do_start(2'd0, 8'd0, 8'd129, 8'd1, 8'd0);
    repeat (6) @(posedge clk);

    // Test 5a: oneshot down 128..0 step 0, stray start during RUN
    cur_test = 5; ev_idx = 0;
    push(0, 8'd0,   1, 1, 0, 0, 0);
    push(4, 8'd128, 1, 1, 0, 0, 0);
    for (int c = 127; c >= 0; c--) push(1, 8'(c), 1, 1, 0, 0, 0);
    push(5, 8'd0, 0, 0, 0, 1, 0);
    do_start(2'd3, 8'd0, 8'd128, 8'd0, 8'd0);
    bus.lo = 8'd1; bus.hi = 8'd2;
    pulse_after(20, 1'b1, 1'b0);
    wait_idle();

    // Test 5b: start and stop together during RUN
    cur_test = 6; ev_idx = 0;
    push(0, 8'd0,   1, 1, 0, 0, 0);
    push(4, 8'd110, 1, 1, 0, 0, 0);
    push(1, 8'd109, 1, 1, 0, 0, 0);
    push(1, 8'd108, 1, 1, 0, 0, 0);
    push(1, 8'd0,   1, 1, 0, 0, 0);
    push(4, 8'd0,   0, 0, 0, 0, 0);
    do_start(2'd3, 8'd100, 8'd110, 8'd0, 8'd0);
    pulse_after(6, 1'b1, 1'b1);
    wait_idle();

    // Test 6: reset at code 64, then a normal run
    cur_test = 7; ev_idx = 0;
    push(0, 8'd0,  1, 1, 0, 0, 0);
    push(7, 8'd16, 1, 1, 0, 0, 0);
    push(3, 8'd32, 1, 1, 0, 0, 0);
    push(3, 8'd48, 1, 1, 0, 0, 0);
    push(3, 8'd64, 1, 1, 0, 0, 0);
    push(1, 8'd0,  0, 0, 0, 0, 0);
    do_start(2'd0, 8'd0, 8'd128, 8'd16, 8'd2);
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    push(0, 8'd0, 1, 1, 0, 0, 0);
    push(4, 8'd5, 1, 1, 0, 0, 0);
    push(1, 8'd6, 1, 1, 0, 0, 0);
    push(1, 8'd7, 1, 1, 0, 0, 0);
    push(1, 8'd0, 1, 1, 0, 0, 0);
    push(4, 8'd0, 0, 0, 0, 1, 0);
    do_start(2'd0, 8'd5, 8'd7, 8'd1, 8'd0);
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dac_ramp_sequencer.md
# dac_ramp_sequencer

Programmable sequencer that drives the 128-source unary current-steering DAC without host intervention. It generates a thermometer-coded 128-bit ON word from an 8-bit code that ramps between configured limits, and controls the DAC enable with fixed arm and drain intervals. It sits between the pin-level control logic and the DAC macro's ON/ONB/EN inputs, as an alternative source to the shift/transfer state register.

## Interface
- SETTLE_CYC, default 4: number of cycles EN is high with ON word zero, both before the first code and after the last code.
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request; samples the config and begins a sequence
- stop  in  1  one-cycle request; aborts any active sequence
- mode  in  2  0=oneshot up, 1=sawtooth, 2=triangle, 3=oneshot down
- lo  in  8  lower code limit, 0..128
- hi  in  8  upper code limit, 0..128
- step  in  8  code increment; 0 is treated as 1
- dwell  in  8  extra cycles each code is held (hold time = dwell+1)
- on_word  out  128  thermometer word; bit i = (i < code)
- dac_en  out  1  DAC enable; feeds the EN inverter pairs
- code  out  8  current code
- busy  out  1  high in every state except IDLE
- wrap  out  1  one-cycle pulse at each period boundary
- done  out  1  one-cycle pulse on return to IDLE after normal completion
- err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, ARM, RUN, DRAIN.
- Reset, applied synchronously while rst_n=0 on a clock edge:
  - state=IDLE
  - code=0, on_word=0
  - dac_en, busy, wrap, done and err all 0
- IDLE: dac_en=0, code=0.
  - start with lo<=hi<=128: latch mode, lo, hi, step and dwell, then go to ARM. Inputs are not sampled again until the next IDLE.
  - start with lo>hi or hi>128: pulse err and stay in IDLE.
- ARM: dac_en=1, code=0, for SETTLE_CYC cycles. Then go to RUN with code=lo (mode 3: code=hi).
- RUN: dac_en=1. Each code is held for dwell+1 cycles, then the code advances. The sum is computed 9 bits wide and clamped to the range [lo, hi].
  - Mode 0: code=min(code+step, hi). After the hold at hi, go to DRAIN.
  - Mode 1: code=min(code+step, hi). After the hold at hi, code=lo and pulse wrap.
  - Mode 2: the direction flag starts up.
    - Up: code=min(code+step, hi); at hi the direction flips to down.
    - Down: code=max(code-step, lo); at lo the direction flips to up and wrap pulses.
    - If lo==hi, code stays constant and wrap pulses every dwell+1 cycles.
  - Mode 3: code=max(code-step, lo). After the hold at lo, go to DRAIN.
  - Modes 1 and 2 run until stop.
- DRAIN: code=0 and on_word=0 immediately; dac_en=1 for SETTLE_CYC cycles, then go to IDLE with dac_en=0.
  - done pulses on the IDLE entry cycle, but only when DRAIN was entered by completion (not by stop).
- stop in ARM or RUN: go to DRAIN on the next cycle with no done pulse. stop in DRAIN or IDLE is ignored.
- start while busy is ignored and raises no err.
- start and stop in the same cycle:
  - In IDLE: start is honoured.
  - Otherwise: stop wins.
- on_word is always a registered decode of code: ones from bit 0 upward, and code=128 gives all ones. ONB is generated by the parent as ~on_word.

## Timing
- start sampled at edge t:
  - t+1: busy=1, dac_en=1, on_word=0
  - t+1+SETTLE_CYC: code=lo
- Code changes occur exactly every dwell+1 cycles. code and on_word update on the same edge.
- wrap is asserted in the same cycle the wrapped code first appears.
- stop sampled at edge t:
  - t+1: code=0, on_word=0
  - t+1+SETTLE_CYC: dac_en=0, busy=0
- dac_en never falls while on_word is nonzero. on_word is never nonzero while dac_en=0.
- rst_n low mid-sequence: outputs are at reset values on the next edge. There is no drain.
- err and done are exactly one cycle wide.

## Test plan
- Reset, then mode 0 with lo=0, hi=10, step=3, dwell=1, SETTLE_CYC=4:
  - dac_en rises at t+1.
  - code sequence is 0,3,6,9,10, each held 2 cycles.
  - DRAIN lasts 4 cycles, then done pulses.
  - on_word=0x3FF while code=10.
- Mode 1 with lo=120, hi=128, step=4, dwell=0:
  - code cycles 120,124,128,120,…
  - on_word is all ones at 128.
  - wrap pulses on each return to 120.
- Mode 2 with lo=2, hi=5, step=2, dwell=0:
  - code sequence is 2,4,5,3,2,4,…
  - wrap pulses at each 2 after the first.
  - stop mid-ramp gives on_word=0 the next cycle, dac_en low 4 cycles later, and no done.
- start with lo=9, hi=4, and separately start with hi=129:
  - err pulses for one cycle each time.
  - busy stays 0 and dac_en stays 0.
- Mode 3 with lo=0, hi=128, step=0:
  - code counts down by 1 from 128 to 0, then drains.
  - start pulses during RUN are ignored.
  - start and stop together during RUN go to DRAIN.
- rst_n low while code=64 in RUN:
  - next edge gives on_word=0, dac_en=0, busy=0.
  - a new start after reset runs normally.
